// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
package trap_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WFI   = 3'd1,
        S_DRAIN = 3'd2,
        S_ENTER = 3'd3,
        S_RET   = 3'd4
    } state_e;

    localparam logic [3:0]  CAUSE_MEI        = 4'd11;
    localparam logic [3:0]  CAUSE_MTI        = 4'd7;
    localparam logic [31:0] ISR_BASE_DEFAULT = 32'h0001_0000;

    // External interrupt outranks the timer when both are pending.
    function automatic logic [3:0] cause_of(input logic ext_pend);
        return ext_pend ? CAUSE_MEI : CAUSE_MTI;
    endfunction

endpackage

// File: rtl/trap_sequencer_if.sv
// Pipeline/CSR-side signal bundle of the trap sequencer.
interface trap_sequencer_if;

    logic        ext_irq;
    logic        tmr_irq;
    logic        mstatus_mie;
    logic        mie_meie;
    logic        mie_mtie;
    logic        im_stall;
    logic        dm_stall;
    logic        mret_req;
    logic        wfi_req;
    logic [31:0] pc_ex;
    logic [31:0] mepc_i;

    logic        trap_take;
    logic [3:0]  trap_cause;
    logic        mepc_we;
    logic [31:0] mepc_wdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mret_done;
    logic        flush;
    logic        wfi_stall;

    modport master (
        output ext_irq, tmr_irq, mstatus_mie, mie_meie, mie_mtie,
               im_stall, dm_stall, mret_req, wfi_req, pc_ex, mepc_i,
        input  trap_take, trap_cause, mepc_we, mepc_wdata, redirect,
               redirect_pc, mret_done, flush, wfi_stall
    );

    modport slave (
        input  ext_irq, tmr_irq, mstatus_mie, mie_meie, mie_mtie,
               im_stall, dm_stall, mret_req, wfi_req, pc_ex, mepc_i,
        output trap_take, trap_cause, mepc_we, mepc_wdata, redirect,
               redirect_pc, mret_done, flush, wfi_stall
    );

endinterface

// File: rtl/trap_sequencer.sv
// Interrupt entry / MRET / WFI sequencer: drains the pipeline, then issues a
// single-cycle trap entry or return with PC redirect.
module trap_sequencer
    import trap_pkg::*;
#(
    parameter logic [31:0] ISR_BASE = ISR_BASE_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    trap_sequencer_if.slave bus
);

    localparam logic [2:0] ST_IDLE  = S_IDLE;
    localparam logic [2:0] ST_WFI   = S_WFI;
    localparam logic [2:0] ST_DRAIN = S_DRAIN;
    localparam logic [2:0] ST_ENTER = S_ENTER;
    localparam logic [2:0] ST_RET   = S_RET;

    logic [2:0]  state_reg, state_next;
    logic [3:0]  cause_reg, cause_next;
    logic [31:0] epc_reg, epc_next;

    logic ext_pend;
    logic tmr_pend;
    logic take;
    logic stall;

    assign ext_pend = bus.ext_irq & bus.mie_meie;
    assign tmr_pend = bus.tmr_irq & bus.mie_mtie;
    assign take     = bus.mstatus_mie & (ext_pend | tmr_pend);
    assign stall    = bus.im_stall | bus.dm_stall;

    always_comb begin
        state_next = state_reg;
        cause_next = cause_reg;
        epc_next   = epc_reg;
        case (state_reg)
            ST_IDLE: begin
                if (take) begin
                    state_next = ST_DRAIN;
                    cause_next = cause_of(ext_pend);
                    epc_next   = bus.pc_ex;
                end else if (bus.mret_req && !stall) begin
                    state_next = ST_RET;
                end else if (bus.wfi_req && !stall) begin
                    state_next = ST_WFI;
                end
            end
            ST_WFI: begin
                // The WFI has retired, so the trap must return past it.
                if (take) begin
                    state_next = ST_DRAIN;
                    cause_next = cause_of(ext_pend);
                    epc_next   = bus.pc_ex + 32'd4;
                end else if ((ext_pend | tmr_pend) && !bus.mstatus_mie) begin
                    state_next = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // Cause and PC are already latched; a dropped IRQ cannot cancel.
                if (!stall) begin
                    state_next = ST_ENTER;
                end
            end
            ST_ENTER: state_next = ST_IDLE;
            ST_RET:   state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cause_reg <= 4'd0;
            epc_reg   <= 32'd0;
        end else begin
            state_reg <= state_next;
            cause_reg <= cause_next;
            epc_reg   <= epc_next;
        end
    end

    // Outputs decode from state alone so async reset clears them immediately.
    always_comb begin
        bus.trap_take   = 1'b0;
        bus.trap_cause  = 4'd0;
        bus.mepc_we     = 1'b0;
        bus.mepc_wdata  = 32'd0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'd0;
        bus.mret_done   = 1'b0;
        bus.flush       = 1'b0;
        bus.wfi_stall   = 1'b0;
        case (state_reg)
            ST_WFI: begin
                bus.wfi_stall = 1'b1;
            end
            ST_DRAIN: begin
                bus.flush = 1'b1;
            end
            ST_ENTER: begin
                bus.trap_take   = 1'b1;
                bus.trap_cause  = cause_reg;
                bus.mepc_we     = 1'b1;
                bus.mepc_wdata  = epc_reg;
                bus.redirect    = 1'b1;
                bus.redirect_pc = ISR_BASE;
                bus.flush       = 1'b1;
            end
            ST_RET: begin
                bus.mret_done   = 1'b1;
                bus.redirect    = 1'b1;
                bus.redirect_pc = bus.mepc_i;
                bus.flush       = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed scenarios plus randomized traffic checked against a behavioural model.
module tb_trap_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    trap_sequencer_if bus ();

    trap_sequencer #(.ISR_BASE(32'h0001_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: which one-cycle or waiting activity is in progress.
    bit          m_wfi, m_drain, m_enter, m_ret;
    int unsigned m_cause;
    logic [31:0] m_epc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic m_clear();
        m_wfi = 0; m_drain = 0; m_enter = 0; m_ret = 0;
        m_cause = 0; m_epc = 32'd0;
    endtask

    task automatic model_step();
        bit ep, tp, tk, st;
        if (rst) begin
            m_clear();
            return;
        end
        ep = bus.ext_irq && bus.mie_meie;
        tp = bus.tmr_irq && bus.mie_mtie;
        tk = bus.mstatus_mie && (ep || tp);
        st = bus.im_stall || bus.dm_stall;
        if (m_enter || m_ret) begin
            m_enter = 0; m_ret = 0;
        end else if (m_drain) begin
            if (!st) begin m_drain = 0; m_enter = 1; end
        end else if (m_wfi) begin
            if (tk) begin
                m_wfi = 0; m_drain = 1;
                m_cause = ep ? 11 : 7;
                m_epc = bus.pc_ex + 32'd4;
            end else if ((ep || tp) && !bus.mstatus_mie) begin
                m_wfi = 0;
            end
        end else if (tk) begin
            m_drain = 1;
            m_cause = ep ? 11 : 7;
            m_epc = bus.pc_ex;
        end else if (bus.mret_req && !st) begin
            m_ret = 1;
        end else if (bus.wfi_req && !st) begin
            m_wfi = 1;
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, ":trap_take"},   bus.trap_take,   m_enter);
        chk({ph, ":trap_cause"},  bus.trap_cause,  m_enter ? m_cause : 0);
        chk({ph, ":mepc_we"},     bus.mepc_we,     m_enter);
        chk({ph, ":mepc_wdata"},  bus.mepc_wdata,  m_enter ? m_epc : 32'd0);
        chk({ph, ":redirect"},    bus.redirect,    m_enter || m_ret);
        chk({ph, ":redirect_pc"}, bus.redirect_pc,
            m_enter ? 32'h0001_0000 : (m_ret ? bus.mepc_i : 32'd0));
        chk({ph, ":mret_done"},   bus.mret_done,   m_ret);
        chk({ph, ":flush"},       bus.flush,       m_drain || m_enter || m_ret);
        chk({ph, ":wfi_stall"},   bus.wfi_stall,   m_wfi);
    endtask

    task automatic cycle(input string ph);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all(ph);
    endtask

    task automatic quiet_inputs();
        bus.ext_irq = 0; bus.tmr_irq = 0;
        bus.mstatus_mie = 1; bus.mie_meie = 1; bus.mie_mtie = 1;
        bus.im_stall = 0; bus.dm_stall = 0;
        bus.mret_req = 0; bus.wfi_req = 0;
        bus.pc_ex = 32'h0000_0800; bus.mepc_i = 32'd0;
    endtask

    initial begin
        int n;
        logic [31:0] seen;
        quiet_inputs();
        bus.mstatus_mie = 0;
        m_clear();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst = 0;
        quiet_inputs();
        cycle("idle");

        // Single external IRQ pulse, no stall.
        bus.pc_ex = 32'h0000_0400; bus.ext_irq = 1;
        cycle("t1_drain");
        chk("t1_flush", bus.flush, 1);
        bus.ext_irq = 0; bus.pc_ex = 32'h0000_0999;
        cycle("t1_enter");
        chk("t1_take", bus.trap_take, 1);
        chk("t1_cause", bus.trap_cause, 11);
        chk("t1_mepc", bus.mepc_wdata, 32'h0000_0400);
        chk("t1_rpc", bus.redirect_pc, 32'h0001_0000);
        cycle("t1_idle");
        chk("t1_take_off", bus.trap_take, 0);

        // Both interrupts pending: external wins, only one entry.
        bus.ext_irq = 1; bus.tmr_irq = 1;
        n = 0; seen = 32'd0;
        for (int i = 0; i < 6; i++) begin
            cycle("t2");
            bus.ext_irq = 0; bus.tmr_irq = 0;
            if (bus.trap_take) begin n++; seen = 32'(bus.trap_cause); end
        end
        chk("t2_takes", n, 1);
        chk("t2_cause", seen, 11);

        // WFI, wake by external IRQ after 5 cycles.
        bus.pc_ex = 32'h0000_0100; bus.wfi_req = 1;
        n = 0;
        cycle("t3_wfi");
        bus.wfi_req = 0;
        if (bus.wfi_stall) n++;
        for (int i = 0; i < 4; i++) begin
            cycle("t3_wait");
            if (bus.wfi_stall) n++;
        end
        bus.ext_irq = 1;
        cycle("t3_drain");
        if (bus.wfi_stall) n++;
        chk("t3_stall_cycles", n, 5);
        bus.ext_irq = 0;
        cycle("t3_enter");
        chk("t3_take", bus.trap_take, 1);
        chk("t3_mepc", bus.mepc_wdata, 32'h0000_0104);
        cycle("t3_idle");

        // Timer trap out of WFI at the top of the address space wraps mepc.
        bus.pc_ex = 32'hFFFF_FFFC; bus.wfi_req = 1;
        cycle("t3b_wfi");
        bus.wfi_req = 0; bus.tmr_irq = 1;
        cycle("t3b_drain");
        bus.tmr_irq = 0;
        cycle("t3b_enter");
        chk("t3b_cause", bus.trap_cause, 7);
        chk("t3b_mepc", bus.mepc_wdata, 32'h0000_0000);
        cycle("t3b_idle");

        // Trap while the data side stalls for 4 cycles.
        bus.dm_stall = 1; bus.ext_irq = 1; bus.pc_ex = 32'h0000_0A00;
        for (int i = 0; i < 4; i++) begin
            cycle("t4_stall");
            bus.ext_irq = 0;
            chk("t4_flush", bus.flush, 1);
            chk("t4_notake", bus.trap_take, 0);
        end
        bus.dm_stall = 0;
        cycle("t4_enter");
        chk("t4_take", bus.trap_take, 1);
        chk("t4_mepc", bus.mepc_wdata, 32'h0000_0A00);
        cycle("t4_idle");

        // MRET.
        bus.mepc_i = 32'h0000_2000; bus.mret_req = 1;
        cycle("t5_ret");
        chk("t5_done", bus.mret_done, 1);
        chk("t5_rpc", bus.redirect_pc, 32'h0000_2000);
        chk("t5_notake", bus.trap_take, 0);
        bus.mret_req = 0;
        cycle("t5_idle");

        // Reset in the middle of a drain abandons the trap.
        bus.dm_stall = 1; bus.ext_irq = 1;
        cycle("t6_drain");
        chk("t6_flush", bus.flush, 1);
        bus.ext_irq = 0;
        #1 rst = 1;
        m_clear();
        #1 check_all("t6_async");
        chk("t6_flush_off", bus.flush, 0);
        cycle("t6_hold");
        rst = 0; bus.dm_stall = 0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            cycle("t6_after");
            if (bus.trap_take || bus.mepc_we) n++;
        end
        chk("t6_no_take", n, 0);
        bus.mepc_i = 32'h0000_3000; bus.mret_req = 1;
        cycle("t6_idle_probe");
        chk("t6_idle_ret", bus.mret_done, 1);
        bus.mret_req = 0;
        cycle("t6_end");

        // Randomized traffic, with an occasional asynchronous reset.
        for (int i = 0; i < 3000; i++) begin
            bus.ext_irq     = ($urandom_range(0, 7) == 0);
            bus.tmr_irq     = ($urandom_range(0, 7) == 0);
            bus.mie_meie    = ($urandom_range(0, 3) != 0);
            bus.mie_mtie    = ($urandom_range(0, 3) != 0);
            bus.mstatus_mie = ($urandom_range(0, 3) != 0);
            bus.im_stall    = ($urandom_range(0, 4) == 0);
            bus.dm_stall    = ($urandom_range(0, 4) == 0);
            bus.mret_req    = ($urandom_range(0, 9) == 0);
            bus.wfi_req     = ($urandom_range(0, 9) == 0);
            bus.pc_ex       = {$urandom()} & 32'hFFFF_FFFC;
            bus.mepc_i      = {$urandom()} & 32'hFFFF_FFFC;
            if ($urandom_range(0, 149) == 0) begin
                #1 rst = 1;
                m_clear();
                #1 check_all("rnd_rst");
            end else begin
                rst = 0;
            end
            cycle("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trap_sequencer.md
TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 SHALL have parameter ISR_BASE, default 32'h0001_0000, meaning the trap vector address driven on redirect at trap entry.
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port ext_irq  in  1  DMA external interrupt, level.
REQ-005 SHALL have port tmr_irq  in  1  WDT timer interrupt, level.
REQ-006 SHALL have port mstatus_mie  in  1  global interrupt enable (mstatus bit 3).
REQ-007 SHALL have ports mie_meie and mie_mtie  in  1 each  local enables (mie bits 11 and 7).
REQ-008 SHALL have ports im_stall and dm_stall  in  1 each  memory stalls; a stall is active when either is 1.
REQ-009 SHALL have ports mret_req and wfi_req  in  1 each  decoded MRET / WFI in execute.
REQ-010 SHALL have ports pc_ex  in  32  execute-stage PC, and mepc_i  in  32  current mepc.
REQ-011 SHALL have port trap_take  out  1  one-cycle trap-entry pulse; the CSR file saves and clears MIE and sets MPP=11.
REQ-012 SHALL have port trap_cause  out  4  cause code, valid with trap_take.
REQ-013 SHALL have ports mepc_we  out  1  and mepc_wdata  out  32  mepc write.
REQ-014 SHALL have ports redirect  out  1  and redirect_pc  out  32  one-cycle PC redirect.
REQ-015 SHALL have ports mret_done  out  1  one-cycle pulse (CSR file restores MIE from MPIE), flush  out  1  pipeline flush, and wfi_stall  out  1  freezes fetch.

Function
REQ-016 SHALL implement FSM states IDLE, WFI, DRAIN, ENTER, RET.
REQ-017 SHALL define ext_pend = ext_irq & mie_meie, tmr_pend = tmr_irq & mie_mtie, and take = mstatus_mie & (ext_pend | tmr_pend).
REQ-018 In IDLE, with priority take > mret_req > wfi_req, SHALL go to DRAIN on take, to RET on mret_req with no stall, and to WFI on wfi_req with no stall; otherwise SHALL stay in IDLE.
REQ-019 On entering DRAIN, SHALL latch the cause (ext_pend -> 11, else tmr_pend -> 7; external wins when both are pending) and the saved PC (pc_ex, or pc_ex+4 when entering from WFI), each 32-bit with wrap-around.
REQ-020 In WFI, SHALL assert wfi_stall=1, go to DRAIN on take, go to IDLE (resume, no trap) when ext_pend|tmr_pend is set with mstatus_mie=0, and otherwise stay.
REQ-021 In DRAIN, SHALL assert flush=1 and go to ENTER on the first cycle with no stall; an interrupt that deasserts during DRAIN SHALL NOT cancel the trap.
REQ-022 ENTER SHALL last exactly 1 cycle with trap_take=1, trap_cause=latched cause, mepc_we=1, mepc_wdata=latched PC, redirect=1, redirect_pc=ISR_BASE, flush=1, and then go to IDLE.
REQ-023 RET SHALL last exactly 1 cycle with mret_done=1, redirect=1, redirect_pc=mepc_i, flush=1, and then go to IDLE.
REQ-024 Latency SHALL be: take in IDLE with no stall -> trap_take 2 cycles later; mret_req with no stall -> redirect 1 cycle later.
REQ-025 When not asserted, all outputs SHALL be 0, and trap_cause and redirect_pc SHALL be 0 outside ENTER/RET.
REQ-026 trap_take and mret_done SHALL never assert in the same cycle.

Reset
REQ-027 While rst=1, SHALL set state to IDLE, latched cause and PC to 0, and drive all outputs to 0, asynchronously.
REQ-028 Reset asserted in any state, including mid-DRAIN, SHALL abandon the trap with no trap_take and no mepc write.

Structure
REQ-029 Package trap_pkg SHALL hold the state enum, cause constants CAUSE_MEI=11 and CAUSE_MTI=7, and the default ISR_BASE.
REQ-030 No sub-module is required; the priority encoder SHALL be inline combinational logic.

Verification
REQ-031 The bench SHALL cover: mie_meie=1, mstatus_mie=1, ext_irq pulse, no stall -> trap_take 2 cycles later, cause=11, mepc_wdata=pc_ex, redirect_pc=0x0001_0000.
REQ-032 The bench SHALL cover: ext_irq and tmr_irq both set with both enables -> cause=11, single trap_take.
REQ-033 The bench SHALL cover: wfi_req at pc_ex=0x100, ext_irq after 5 cycles -> wfi_stall high for 5 cycles, then trap with mepc_wdata=0x104.
REQ-034 The bench SHALL cover: take while dm_stall held 4 cycles -> flush=1 throughout DRAIN, trap_take on the first cycle after the stall clears.
REQ-035 The bench SHALL cover: mret_req with mepc_i=0x2000, no stall -> next cycle mret_done=1 and redirect_pc=0x2000.
REQ-036 The bench SHALL cover: rst asserted mid-DRAIN -> all outputs 0 immediately, no trap_take, state IDLE after release.
